// File: rtl/obj_ctrl_pkg.sv
// rtl/obj_ctrl_pkg.sv - shared types and widths for the object frame controller
package obj_ctrl_pkg;
    localparam int COORD_W = 10;
    localparam int COUNT_W = 19;
    localparam int SUM_W   = 28;

    localparam logic CFG_ADDR_THRESH    = 1'b0;
    localparam logic CFG_ADDR_MIN_COUNT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_ACTIVE,
        ST_REPORT
    } state_e;
endpackage

// File: rtl/obj_bbox_accum.sv
// rtl/obj_bbox_accum.sv - per-frame min/max/count (and OBJ_CENTROID_EN sums) accumulator
module obj_bbox_accum
    import obj_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               hit,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] min_x,
    output logic [COORD_W-1:0] max_x,
    output logic [COORD_W-1:0] min_y,
    output logic [COORD_W-1:0] max_y,
    output logic [COUNT_W-1:0] count
`ifdef OBJ_CENTROID_EN
    ,
    output logic [SUM_W-1:0]   sum_x,
    output logic [SUM_W-1:0]   sum_y
`endif
);
    logic [COORD_W-1:0] min_x_q, max_x_q, min_y_q, max_y_q;
    logic [COORD_W-1:0] min_x_d, max_x_d, min_y_d, max_y_d;
    logic [COUNT_W-1:0] count_q, count_d;
`ifdef OBJ_CENTROID_EN
    logic [SUM_W-1:0]   sum_x_q, sum_y_q, sum_x_d, sum_y_d;
`endif

    // start re-seeds the bounds; a hit on that same cycle folds in on top
    always_comb begin
        min_x_d = start ? '1 : min_x_q;
        min_y_d = start ? '1 : min_y_q;
        max_x_d = start ? '0 : max_x_q;
        max_y_d = start ? '0 : max_y_q;
        count_d = start ? '0 : count_q;
`ifdef OBJ_CENTROID_EN
        sum_x_d = start ? '0 : sum_x_q;
        sum_y_d = start ? '0 : sum_y_q;
`endif
        if (hit) begin
            if (x < min_x_d) min_x_d = x;
            if (x > max_x_d) max_x_d = x;
            if (y < min_y_d) min_y_d = y;
            if (y > max_y_d) max_y_d = y;
            if (count_d != '1) count_d = count_d + 1'b1;
`ifdef OBJ_CENTROID_EN
            sum_x_d = sum_x_d + SUM_W'(x);
            sum_y_d = sum_y_d + SUM_W'(y);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_x_q <= '1;
            min_y_q <= '1;
            max_x_q <= '0;
            max_y_q <= '0;
            count_q <= '0;
`ifdef OBJ_CENTROID_EN
            sum_x_q <= '0;
            sum_y_q <= '0;
`endif
        end else begin
            min_x_q <= min_x_d;
            min_y_q <= min_y_d;
            max_x_q <= max_x_d;
            max_y_q <= max_y_d;
            count_q <= count_d;
`ifdef OBJ_CENTROID_EN
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
`endif
        end
    end

    assign min_x = min_x_q;
    assign max_x = max_x_q;
    assign min_y = min_y_q;
    assign max_y = max_y_q;
    assign count = count_q;
`ifdef OBJ_CENTROID_EN
    assign sum_x = sum_x_q;
    assign sum_y = sum_y_q;
`endif
endmodule

// File: rtl/object_frame_ctrl.sv
// rtl/object_frame_ctrl.sv - frame capture FSM, config shadowing and result handshake; OBJ_CENTROID_EN adds coordinate sums
module object_frame_ctrl
    import obj_ctrl_pkg::*;
#(
    parameter int THRESH_RESET    = 16,
    parameter int MIN_COUNT_RESET = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               cfg_wr,
    input  logic               cfg_addr,
    input  logic [15:0]        cfg_wdata,
    output logic [4:0]         threshold,
    input  logic               object_pixel,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               pixel_valid,
    input  logic               frame_valid,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_found,
    output logic [COORD_W-1:0] res_min_x,
    output logic [COORD_W-1:0] res_max_x,
    output logic [COORD_W-1:0] res_min_y,
    output logic [COORD_W-1:0] res_max_y,
    output logic [COUNT_W-1:0] res_count,
    output logic               overrun,
    input  logic               overrun_clr
`ifdef OBJ_CENTROID_EN
    ,
    output logic [SUM_W-1:0]   res_sum_x,
    output logic [SUM_W-1:0]   res_sum_y
`endif
);
    state_e state_q, state_d;
    logic   fv_q;
    logic [4:0]  pend_thresh_q, pend_thresh_d, act_thresh_q, act_thresh_d;
    logic [15:0] pend_min_q, pend_min_d, act_min_q, act_min_d;
    logic        res_valid_q, res_valid_d, res_found_q, res_found_d;
    logic        overrun_q, overrun_d;
    logic [COORD_W-1:0] res_min_x_q, res_max_x_q, res_min_y_q, res_max_y_q;
    logic [COORD_W-1:0] res_min_x_d, res_max_x_d, res_min_y_d, res_max_y_d;
    logic [COUNT_W-1:0] res_count_q, res_count_d;

    logic sof, eof, hs, acc_start, acc_hit, load_res, found;
    logic [COORD_W-1:0] acc_min_x, acc_max_x, acc_min_y, acc_max_y;
    logic [COUNT_W-1:0] acc_count;
`ifdef OBJ_CENTROID_EN
    logic [SUM_W-1:0] acc_sum_x, acc_sum_y;
    logic [SUM_W-1:0] res_sum_x_q, res_sum_y_q, res_sum_x_d, res_sum_y_d;
`endif

    assign sof = frame_valid & ~fv_q;
    assign eof = ~frame_valid & fv_q;
    assign hs  = res_valid_q & res_ready;

    always_comb begin
        state_d   = state_q;
        acc_start = 1'b0;
        load_res  = 1'b0;
        case (state_q)
            ST_IDLE:     if (enable) state_d = ST_WAIT_SOF;
            ST_WAIT_SOF: begin
                if (!enable) state_d = ST_IDLE;
                else if (sof) begin
                    state_d   = ST_ACTIVE;
                    acc_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!enable) state_d = ST_IDLE;
                else if (eof) begin
                    state_d  = ST_REPORT;
                    load_res = 1'b1;
                end
            end
            ST_REPORT: begin
                if (hs) begin
                    if (!enable) state_d = ST_IDLE;
                    else if (sof) begin
                        state_d   = ST_ACTIVE;
                        acc_start = 1'b1;
                    end else state_d = ST_WAIT_SOF;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign acc_hit = (state_q == ST_ACTIVE || acc_start) & frame_valid & pixel_valid & object_pixel;
    assign found   = acc_count >= COUNT_W'(act_min_q);

    obj_bbox_accum u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .start (acc_start),
        .hit   (acc_hit),
        .x     (x),
        .y     (y),
        .min_x (acc_min_x),
        .max_x (acc_max_x),
        .min_y (acc_min_y),
        .max_y (acc_max_y),
        .count (acc_count)
`ifdef OBJ_CENTROID_EN
        ,
        .sum_x (acc_sum_x),
        .sum_y (acc_sum_y)
`endif
    );

    // config is shadowed and only takes effect at a frame boundary
    always_comb begin
        pend_thresh_d = pend_thresh_q;
        pend_min_d    = pend_min_q;
        act_thresh_d  = act_thresh_q;
        act_min_d     = act_min_q;
        if (cfg_wr) begin
            if (cfg_addr == CFG_ADDR_THRESH) pend_thresh_d = cfg_wdata[4:0];
            else                             pend_min_d    = cfg_wdata;
        end
        if (sof) begin
            act_thresh_d = pend_thresh_q;
            act_min_d    = pend_min_q;
        end
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_found_d = res_found_q;
        res_min_x_d = res_min_x_q;
        res_max_x_d = res_max_x_q;
        res_min_y_d = res_min_y_q;
        res_max_y_d = res_max_y_q;
        res_count_d = res_count_q;
`ifdef OBJ_CENTROID_EN
        res_sum_x_d = res_sum_x_q;
        res_sum_y_d = res_sum_y_q;
`endif
        if (load_res) begin
            res_valid_d = 1'b1;
            res_found_d = found;
            res_min_x_d = found ? acc_min_x : '0;
            res_max_x_d = found ? acc_max_x : '0;
            res_min_y_d = found ? acc_min_y : '0;
            res_max_y_d = found ? acc_max_y : '0;
            res_count_d = acc_count;
`ifdef OBJ_CENTROID_EN
            res_sum_x_d = acc_sum_x;
            res_sum_y_d = acc_sum_y;
`endif
        end else if (hs) begin
            res_valid_d = 1'b0;
        end
        overrun_d = overrun_q;
        if (overrun_clr) overrun_d = 1'b0;
        if (state_q == ST_REPORT && sof && !hs) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            fv_q          <= 1'b0;
            pend_thresh_q <= 5'(THRESH_RESET);
            act_thresh_q  <= 5'(THRESH_RESET);
            pend_min_q    <= 16'(MIN_COUNT_RESET);
            act_min_q     <= 16'(MIN_COUNT_RESET);
            res_valid_q   <= 1'b0;
            res_found_q   <= 1'b0;
            res_min_x_q   <= '0;
            res_max_x_q   <= '0;
            res_min_y_q   <= '0;
            res_max_y_q   <= '0;
            res_count_q   <= '0;
            overrun_q     <= 1'b0;
`ifdef OBJ_CENTROID_EN
            res_sum_x_q   <= '0;
            res_sum_y_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            fv_q          <= frame_valid;
            pend_thresh_q <= pend_thresh_d;
            act_thresh_q  <= act_thresh_d;
            pend_min_q    <= pend_min_d;
            act_min_q     <= act_min_d;
            res_valid_q   <= res_valid_d;
            res_found_q   <= res_found_d;
            res_min_x_q   <= res_min_x_d;
            res_max_x_q   <= res_max_x_d;
            res_min_y_q   <= res_min_y_d;
            res_max_y_q   <= res_max_y_d;
            res_count_q   <= res_count_d;
            overrun_q     <= overrun_d;
`ifdef OBJ_CENTROID_EN
            res_sum_x_q   <= res_sum_x_d;
            res_sum_y_q   <= res_sum_y_d;
`endif
        end
    end

    assign threshold = act_thresh_q;
    assign res_valid = res_valid_q;
    assign res_found = res_found_q;
    assign res_min_x = res_min_x_q;
    assign res_max_x = res_max_x_q;
    assign res_min_y = res_min_y_q;
    assign res_max_y = res_max_y_q;
    assign res_count = res_count_q;
    assign overrun   = overrun_q;
`ifdef OBJ_CENTROID_EN
    assign res_sum_x = res_sum_x_q;
    assign res_sum_y = res_sum_y_q;
`endif
endmodule

// File: tb/tb_object_frame_ctrl.sv
// tb/tb_object_frame_ctrl.sv - directed self-checking bench for object_frame_ctrl
module tb_object_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, enable, cfg_wr, cfg_addr;
    logic [15:0] cfg_wdata;
    logic [4:0]  threshold;
    logic        object_pixel, pixel_valid, frame_valid;
    logic [9:0]  x, y;
    logic        res_valid, res_ready, res_found, overrun, overrun_clr;
    logic [9:0]  res_min_x, res_max_x, res_min_y, res_max_y;
    logic [18:0] res_count;
`ifdef OBJ_CENTROID_EN
    logic [27:0] res_sum_x, res_sum_y;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    object_frame_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .threshold    (threshold),
        .object_pixel (object_pixel),
        .x            (x),
        .y            (y),
        .pixel_valid  (pixel_valid),
        .frame_valid  (frame_valid),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_found    (res_found),
        .res_min_x    (res_min_x),
        .res_max_x    (res_max_x),
        .res_min_y    (res_min_y),
        .res_max_y    (res_max_y),
        .res_count    (res_count),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
`ifdef OBJ_CENTROID_EN
        ,
        .res_sum_x    (res_sum_x),
        .res_sum_y    (res_sum_y)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pix(input int px, input int py, input logic obj);
        pixel_valid  = 1'b1;
        object_pixel = obj;
        x = px[9:0];
        y = py[9:0];
        tick();
        pixel_valid  = 1'b0;
        object_pixel = 1'b0;
    endtask

    task automatic cfg(input logic a, input int d);
        cfg_wr    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d[15:0];
        tick();
        cfg_wr    = 1'b0;
    endtask

    task automatic chk_res(input string tag, input int fnd, input int mnx, input int mxx,
                           input int mny, input int mxy, input int cnt);
        chk({tag, ".valid"}, 32'(res_valid), 1);
        chk({tag, ".found"}, 32'(res_found), 32'(fnd));
        chk({tag, ".min_x"}, 32'(res_min_x), 32'(mnx));
        chk({tag, ".max_x"}, 32'(res_max_x), 32'(mxx));
        chk({tag, ".min_y"}, 32'(res_min_y), 32'(mny));
        chk({tag, ".max_y"}, 32'(res_max_y), 32'(mxy));
        chk({tag, ".count"}, 32'(res_count), 32'(cnt));
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; cfg_wr = 1'b0; cfg_addr = 1'b0; cfg_wdata = '0;
        object_pixel = 1'b0; pixel_valid = 1'b0; frame_valid = 1'b0; x = '0; y = '0;
        res_ready = 1'b0; overrun_clr = 1'b0;
        tick(); tick();
        chk("rst.valid", 32'(res_valid), 0);
        chk("rst.threshold", 32'(threshold), 16);
        chk("rst.overrun", 32'(overrun), 0);
        chk("rst.count", 32'(res_count), 0);
        chk("rst.found", 32'(res_found), 0);

        // frame 1: min_count 3, three object pixels plus ignored ones
        rst_n = 1'b1; enable = 1'b1;
        tick();
        cfg(1'b1, 3);
        frame_valid = 1'b1; tick();
        pix(10, 20, 1'b1);
        pix(100, 5, 1'b1);
        pix(0, 0, 1'b0);
        object_pixel = 1'b1; x = 10'd1; y = 10'd1; tick(); object_pixel = 1'b0;
        pix(50, 200, 1'b1);
        frame_valid = 1'b0;
        chk("f1.pre_eof_valid", 32'(res_valid), 0);
        tick();
        chk_res("f1", 1, 10, 100, 5, 200, 3);
        tick(); tick();
        chk("f1.hold_count", 32'(res_count), 3);
        chk("f1.hold_valid", 32'(res_valid), 1);
        handshake();
        chk("f1.after_hs_valid", 32'(res_valid), 0);

        // frame 2: min_count 4 -> not found, bbox forced to zero
        cfg(1'b1, 4);
        frame_valid = 1'b1; tick();
        pix(10, 20, 1'b1);
        pix(100, 5, 1'b1);
        pix(50, 200, 1'b1);
        frame_valid = 1'b0; tick();
        chk_res("f2", 0, 0, 0, 0, 0, 3);

        // next frame arrives without handshake -> overrun, skipped
        tick();
        frame_valid = 1'b1; tick();
        chk("ovr.set", 32'(overrun), 1);
        pix(7, 7, 1'b1);
        frame_valid = 1'b0; tick(); tick();
        chk("ovr.count_unchanged", 32'(res_count), 3);
        chk("ovr.valid_held", 32'(res_valid), 1);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        chk("ovr.cleared", 32'(overrun), 0);
        handshake();

        // threshold written mid-frame applies only at the following SOF
        frame_valid = 1'b1; tick();
        chk("thr.sof1", 32'(threshold), 16);
        cfg(1'b0, 20);
        chk("thr.mid", 32'(threshold), 16);
        pix(3, 3, 1'b1);
        frame_valid = 1'b0; tick();
        chk("thr.eof", 32'(threshold), 16);
        handshake();
        chk("thr.before_sof", 32'(threshold), 16);
        frame_valid = 1'b1; tick();
        chk("thr.next_sof", 32'(threshold), 20);

        // asynchronous reset during ACTIVE
        pix(4, 4, 1'b1);
        rst_n = 1'b0; #1;
        chk("arst.valid", 32'(res_valid), 0);
        chk("arst.threshold", 32'(threshold), 16);
        tick(); rst_n = 1'b1;
        tick(); tick();
        pix(5, 5, 1'b1);
        frame_valid = 1'b0; tick();
        chk("arst.no_result", 32'(res_valid), 0);
        tick();
        chk("arst.no_result2", 32'(res_valid), 0);
        frame_valid = 1'b1; tick();
        pix(5, 6, 1'b1);
        frame_valid = 1'b0; tick();
        chk_res("arst.fresh", 0, 0, 0, 0, 0, 1);

        // handshake on the SOF cycle goes straight to capture
        res_ready = 1'b1; frame_valid = 1'b1; tick(); res_ready = 1'b0;
        chk("hs_sof.valid", 32'(res_valid), 0);
        chk("hs_sof.overrun", 32'(overrun), 0);
        pix(9, 9, 1'b1);
        pix(2, 3, 1'b1);
        frame_valid = 1'b0; tick();
        chk("hs_sof.res_valid", 32'(res_valid), 1);
        chk("hs_sof.count", 32'(res_count), 2);
        handshake();

        // enable dropped mid-frame aborts without a result
        frame_valid = 1'b1; tick();
        pix(1, 1, 1'b1);
        enable = 1'b0; tick(); enable = 1'b1;
        frame_valid = 1'b0; tick(); tick();
        chk("abort.valid", 32'(res_valid), 0);

`ifdef OBJ_CENTROID_EN
        cfg(1'b1, 1);
        frame_valid = 1'b1; tick();
        pix(1, 2, 1'b1);
        pix(3, 4, 1'b1);
        frame_valid = 1'b0; tick();
        chk("cent.found", 32'(res_found), 1);
        chk("cent.sum_x", 32'(res_sum_x), 4);
        chk("cent.sum_y", 32'(res_sum_y), 6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
